// File: rtl/riscv_apu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// riscv_apu_arbiter_pkg
// Shared constants and types for the APU arbiter slice.
//   APU_OP_W     : default APU opcode width
//   APU_NARGS    : default number of 32-bit operands per request
//   APU_FLAGS_W  : width of the fflags field returned by the APU
//   APU_DATA_W   : operand / result width
//   apu_req_t    : packed opcode + operand bundle for one APU request
//   wrap_inc     : modulo-N increment used by the round-robin pointer
// ---------------------------------------------------------------------------
package riscv_apu_arbiter_pkg;

    localparam int APU_OP_W    = 6;
    localparam int APU_NARGS   = 3;
    localparam int APU_FLAGS_W = 5;
    localparam int APU_DATA_W  = 32;

    typedef struct packed {
        logic [APU_OP_W-1:0]               op;
        logic [APU_NARGS*APU_DATA_W-1:0]   args;
    } apu_req_t;

    // Increment v and wrap to zero at n (n need not be a power of two).
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/riscv_apu_tag_fifo.sv
// ---------------------------------------------------------------------------
// riscv_apu_tag_fifo
// Records which requester issued each outstanding APU transaction, in issue
// order, so in-order responses can be routed back.
// Pointers carry one extra MSB so full and empty are distinguishable.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset (empties FIFO)
//   push, push_tag    : write a tag (ignored when full)
//   pop               : drop the head tag (ignored when empty)
//   pop_tag           : tag at the head of the FIFO
//   full, empty       : occupancy status
// ---------------------------------------------------------------------------
module riscv_apu_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic [TAG_W-1:0] pop_tag,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [TAG_W-1:0] mem_q [DEPTH];

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_tag = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_tag;
        end
    end

endmodule

// File: rtl/riscv_apu_arbiter.sv
// ---------------------------------------------------------------------------
// riscv_apu_arbiter
// Round-robin arbiter sharing one pipelined APU between NUM_REQ requesters.
// Grants are combinational (zero latency); in-order responses are routed back
// to the issuing requester via a tag FIFO.
// Optional feature macro: RISCV_APU_ARB_PERF_EN adds per-requester 16-bit
// saturating stall counters with ports perf_clr_i and perf_cnt_o.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   req_i / gnt_o              : per-requester request / grant
//   op_i, args_i               : per-requester opcode and operands (flat)
//   rvalid_o, result_o, flags_o: response valid (one-hot), shared result/flags
//   apu_req_o / apu_gnt_i      : request handshake toward the APU
//   apu_op_o, apu_args_o       : selected opcode and operands
//   apu_rvalid_i, apu_result_i, apu_flags_i : APU response (in order)
//   perf_clr_i, perf_cnt_o     : stall counter clear / values (optional)
// ---------------------------------------------------------------------------
module riscv_apu_arbiter
    import riscv_apu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 4,
    parameter int OP_W    = APU_OP_W,
    parameter int NARGS   = APU_NARGS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    input  logic [NUM_REQ*OP_W-1:0]       op_i,
    input  logic [NUM_REQ*NARGS*32-1:0]   args_i,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic [31:0]                   result_o,
    output logic [APU_FLAGS_W-1:0]        flags_o,
    output logic                          apu_req_o,
    input  logic                          apu_gnt_i,
    output logic [OP_W-1:0]               apu_op_o,
    output logic [NARGS*32-1:0]           apu_args_o,
    input  logic                          apu_rvalid_i,
    input  logic [31:0]                   apu_result_i,
    input  logic [APU_FLAGS_W-1:0]        apu_flags_i
`ifdef RISCV_APU_ARB_PERF_EN
    ,
    input  logic                          perf_clr_i,
    output logic [NUM_REQ*16-1:0]         perf_cnt_o
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] rr_q;
    logic            lock_q;
    logic [ID_W-1:0] lock_id_q;

    logic            win_valid;
    logic [ID_W-1:0] win_id;
    logic            issue;
    logic            fifo_full;
    logic            fifo_empty;
    logic [ID_W-1:0] head_id;
    logic            resp_pop;

    // A locked request must be presented unchanged until the APU accepts it,
    // so the lock overrides the round-robin search.
    always_comb begin
        int idx;
        win_valid = 1'b0;
        win_id    = '0;
        idx       = 0;
        if (lock_q) begin
            win_valid = 1'b1;
            win_id    = lock_id_q;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (!win_valid && req_i[idx]) begin
                    win_valid = 1'b1;
                    win_id    = ID_W'(idx);
                end
            end
        end
    end

    // Full is checked against registered occupancy only, keeping rvalid out
    // of the request path.
    assign apu_req_o  = win_valid && !fifo_full;
    assign issue      = apu_req_o && apu_gnt_i;
    assign apu_op_o   = win_valid ? op_i[int'(win_id)*OP_W +: OP_W] : '0;
    assign apu_args_o = win_valid ? args_i[int'(win_id)*NARGS*32 +: NARGS*32] : '0;

    // Responses with no outstanding tag are dropped rather than misrouted.
    assign resp_pop = apu_rvalid_i && !fifo_empty;
    assign result_o = resp_pop ? apu_result_i : '0;
    assign flags_o  = resp_pop ? apu_flags_i  : '0;

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_o[i]    = issue    && (int'(win_id)  == i);
            rvalid_o[i] = resp_pop && (int'(head_id) == i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q      <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else if (issue) begin
            rr_q   <= ID_W'(wrap_inc(int'(win_id), NUM_REQ));
            lock_q <= 1'b0;
        end else if (apu_req_o) begin
            lock_q    <= 1'b1;
            lock_id_q <= win_id;
        end
    end

    riscv_apu_tag_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (ID_W)
    ) u_tag_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (issue),
        .push_tag (win_id),
        .pop      (resp_pop),
        .pop_tag  (head_id),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // A response with nothing outstanding is a protocol error by the APU.
    always_ff @(posedge clk) begin
        if (rst_n && apu_rvalid_i) begin
            assert (!fifo_empty)
                else $warning("riscv_apu_arbiter: APU response with no outstanding transaction dropped");
        end
    end

`ifdef RISCV_APU_ARB_PERF_EN
    logic [15:0] perf_cnt_q [NUM_REQ];

    // Stall = requesting but not granted this cycle; saturates at 0xFFFF.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst_n || perf_clr_i) begin
                perf_cnt_q[i] <= '0;
            end else if (req_i[i] && !gnt_o[i] && (perf_cnt_q[i] != 16'hFFFF)) begin
                perf_cnt_q[i] <= perf_cnt_q[i] + 16'd1;
            end
        end
    end

    always_comb begin
        perf_cnt_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            perf_cnt_o[i*16 +: 16] = perf_cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_riscv_apu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_riscv_apu_arbiter
// Directed testbench for riscv_apu_arbiter (NUM_REQ=4, DEPTH=4).
// Inputs are driven at the falling edge and outputs sampled 1 time unit later.
// With RISCV_APU_ARB_PERF_EN defined the stall counters are exercised too.
// ---------------------------------------------------------------------------
module tb_riscv_apu_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DEPTH   = 4;
    localparam int OP_W    = 6;
    localparam int NARGS   = 3;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [NUM_REQ-1:0]          req_i;
    logic [NUM_REQ-1:0]          gnt_o;
    logic [NUM_REQ*OP_W-1:0]     op_i;
    logic [NUM_REQ*NARGS*32-1:0] args_i;
    logic [NUM_REQ-1:0]          rvalid_o;
    logic [31:0]                 result_o;
    logic [4:0]                  flags_o;
    logic                        apu_req_o;
    logic                        apu_gnt_i;
    logic [OP_W-1:0]             apu_op_o;
    logic [NARGS*32-1:0]         apu_args_o;
    logic                        apu_rvalid_i;
    logic [31:0]                 apu_result_i;
    logic [4:0]                  apu_flags_i;
`ifdef RISCV_APU_ARB_PERF_EN
    logic                        perf_clr_i;
    logic [NUM_REQ*16-1:0]       perf_cnt_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    riscv_apu_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DEPTH   (DEPTH),
        .OP_W    (OP_W),
        .NARGS   (NARGS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .op_i         (op_i),
        .args_i       (args_i),
        .rvalid_o     (rvalid_o),
        .result_o     (result_o),
        .flags_o      (flags_o),
        .apu_req_o    (apu_req_o),
        .apu_gnt_i    (apu_gnt_i),
        .apu_op_o     (apu_op_o),
        .apu_args_o   (apu_args_o),
        .apu_rvalid_i (apu_rvalid_i),
        .apu_result_i (apu_result_i),
        .apu_flags_i  (apu_flags_i)
`ifdef RISCV_APU_ARB_PERF_EN
        ,
        .perf_clr_i   (perf_clr_i),
        .perf_cnt_o   (perf_cnt_o)
`endif
    );

    // Advance to the next falling edge (one rising edge has passed).
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_i        = '0;
        op_i         = '0;
        args_i       = '0;
        apu_gnt_i    = 1'b0;
        apu_rvalid_i = 1'b0;
        apu_result_i = '0;
        apu_flags_i  = '0;
`ifdef RISCV_APU_ARB_PERF_EN
        perf_clr_i   = 1'b0;
`endif
    endtask

    // Leaves rst_n released at a falling edge; next rising edge is normal.
    task automatic do_reset();
        tick();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        #1;
        n_cmp++; if (gnt_o !== 4'b0000) begin n_bad++; $display("[TB] FAIL reset_gnt: got %b want 0000", gnt_o); end
        n_cmp++; if (rvalid_o !== 4'b0000) begin n_bad++; $display("[TB] FAIL reset_rvalid: got %b want 0000", rvalid_o); end
        n_cmp++; if (apu_req_o !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_apu_req: got %b want 0", apu_req_o); end
        n_cmp++; if ({apu_op_o, apu_args_o, result_o, flags_o} !== '0) begin n_bad++; $display("[TB] FAIL reset_data: got op %h res %h want 0", apu_op_o, result_o); end
        tick();
        rst_n = 1'b1;
        tick();
        #1;
        n_cmp++; if ({gnt_o, rvalid_o, apu_req_o} !== 9'b0) begin n_bad++; $display("[TB] FAIL post_reset: got gnt %b rvalid %b req %b want 0", gnt_o, rvalid_o, apu_req_o); end
    endtask

    task automatic test_single();
        do_reset();
        req_i[2]               = 1'b1;
        op_i[2*OP_W +: OP_W]   = 6'h01;
        args_i[2*96 +: 96]     = {32'h0000_0000, 32'h4000_0000, 32'h3F80_0000};
        apu_gnt_i              = 1'b1;
        #1;
        n_cmp++; if (gnt_o !== 4'b0100) begin n_bad++; $display("[TB] FAIL single_gnt: got %b want 0100", gnt_o); end
        n_cmp++; if (apu_req_o !== 1'b1) begin n_bad++; $display("[TB] FAIL single_apu_req: got %b want 1", apu_req_o); end
        n_cmp++; if (apu_op_o !== 6'h01) begin n_bad++; $display("[TB] FAIL single_op: got %h want 01", apu_op_o); end
        n_cmp++; if (apu_args_o !== 96'h00000000_40000000_3F800000) begin n_bad++; $display("[TB] FAIL single_args: got %h want 00000000400000003f800000", apu_args_o); end
        tick();
        req_i     = '0;
        apu_gnt_i = 1'b0;
        #1;
        n_cmp++; if ({apu_op_o, apu_req_o} !== 7'b0) begin n_bad++; $display("[TB] FAIL idle_op: got op %h req %b want 0", apu_op_o, apu_req_o); end
        tick();
        tick();
        apu_rvalid_i = 1'b1;
        apu_result_i = 32'h4040_0000;
        apu_flags_i  = 5'h01;
        #1;
        n_cmp++; if (rvalid_o !== 4'b0100) begin n_bad++; $display("[TB] FAIL single_rvalid: got %b want 0100", rvalid_o); end
        n_cmp++; if (result_o !== 32'h4040_0000) begin n_bad++; $display("[TB] FAIL single_result: got %h want 40400000", result_o); end
        n_cmp++; if (flags_o !== 5'h01) begin n_bad++; $display("[TB] FAIL single_flags: got %h want 01", flags_o); end
        tick();
        apu_rvalid_i = 1'b0;
        #1;
        n_cmp++; if ({rvalid_o, result_o} !== 36'b0) begin n_bad++; $display("[TB] FAIL single_rvalid_low: got %b %h want 0", rvalid_o, result_o); end
    endtask

    // Responses trail issues by one cycle, so push and pop overlap.
    task automatic test_round_robin();
        logic [3:0] exp_gnt [5];
        logic [3:0] exp_rv  [6];
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_rv  = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            req_i        = (c < 5) ? 4'b1111 : 4'b0000;
            apu_gnt_i    = 1'b1;
            apu_rvalid_i = (c > 0);
            apu_result_i = 32'h100 + c;
            #1;
            if (c < 5) begin
                n_cmp++; if (gnt_o !== exp_gnt[c]) begin n_bad++; $display("[TB] FAIL rr_gnt[%0d]: got %b want %b", c, gnt_o, exp_gnt[c]); end
            end
            n_cmp++; if (rvalid_o !== exp_rv[c]) begin n_bad++; $display("[TB] FAIL rr_rvalid[%0d]: got %b want %b", c, rvalid_o, exp_rv[c]); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        op_i[1*OP_W +: OP_W] = 6'h11;
        op_i[0*OP_W +: OP_W] = 6'h22;
        req_i     = 4'b0010;
        apu_gnt_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (apu_op_o !== 6'h11) begin n_bad++; $display("[TB] FAIL lock_op[%0d]: got %h want 11", c, apu_op_o); end
            n_cmp++; if (gnt_o !== 4'b0000) begin n_bad++; $display("[TB] FAIL lock_gnt[%0d]: got %b want 0000", c, gnt_o); end
            tick();
            req_i = 4'b0011;
        end
        apu_gnt_i = 1'b1;
        #1;
        n_cmp++; if (gnt_o !== 4'b0010) begin n_bad++; $display("[TB] FAIL lock_release: got %b want 0010", gnt_o); end
        tick();
        req_i = 4'b0001;
        #1;
        n_cmp++; if (gnt_o !== 4'b0001 || apu_op_o !== 6'h22) begin n_bad++; $display("[TB] FAIL lock_next: got %b/%h want 0001/22", gnt_o, apu_op_o); end
        tick();
        req_i        = '0;
        apu_rvalid_i = 1'b1;
        #1;
        n_cmp++; if (rvalid_o !== 4'b0010) begin n_bad++; $display("[TB] FAIL lock_rv0: got %b want 0010", rvalid_o); end
        tick();
        #1;
        n_cmp++; if (rvalid_o !== 4'b0001) begin n_bad++; $display("[TB] FAIL lock_rv1: got %b want 0001", rvalid_o); end
        tick();
        clear_inputs();
    endtask

    task automatic test_full();
        do_reset();
        req_i     = 4'b0001;
        apu_gnt_i = 1'b1;
        for (int c = 0; c < DEPTH; c++) begin
            #1;
            n_cmp++; if (gnt_o !== 4'b0001) begin n_bad++; $display("[TB] FAIL fill_gnt[%0d]: got %b want 0001", c, gnt_o); end
            tick();
        end
        #1;
        n_cmp++; if (apu_req_o !== 1'b0 || gnt_o !== 4'b0000) begin n_bad++; $display("[TB] FAIL full_block: got req %b gnt %b want 0/0000", apu_req_o, gnt_o); end
        tick();
        apu_rvalid_i = 1'b1;
        #1;
        n_cmp++; if (apu_req_o !== 1'b0) begin n_bad++; $display("[TB] FAIL full_pop_same: got req %b want 0", apu_req_o); end
        n_cmp++; if (rvalid_o !== 4'b0001) begin n_bad++; $display("[TB] FAIL full_pop_rv: got %b want 0001", rvalid_o); end
        tick();
        apu_rvalid_i = 1'b0;
        #1;
        n_cmp++; if (apu_req_o !== 1'b1 || gnt_o !== 4'b0001) begin n_bad++; $display("[TB] FAIL full_resume: got req %b gnt %b want 1/0001", apu_req_o, gnt_o); end
        tick();
        req_i        = '0;
        apu_rvalid_i = 1'b1;
        for (int c = 0; c < DEPTH; c++) begin
            #1;
            n_cmp++; if (rvalid_o !== 4'b0001) begin n_bad++; $display("[TB] FAIL drain_rv[%0d]: got %b want 0001", c, rvalid_o); end
            tick();
        end
        #1;
        n_cmp++; if (rvalid_o !== 4'b0000) begin n_bad++; $display("[TB] FAIL drain_empty: got %b want 0000", rvalid_o); end
        tick();
        clear_inputs();
    endtask

    task automatic test_interleave();
        logic [3:0]  ids   [3];
        logic [31:0] res   [3];
        ids = '{4'b1000, 4'b0001, 4'b0100};
        res = '{32'hAAAA_0003, 32'hBBBB_0000, 32'hCCCC_0002};
        do_reset();
        apu_gnt_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            req_i = ids[c];
            #1;
            n_cmp++; if (gnt_o !== ids[c]) begin n_bad++; $display("[TB] FAIL il_gnt[%0d]: got %b want %b", c, gnt_o, ids[c]); end
            tick();
        end
        req_i        = '0;
        apu_gnt_i    = 1'b0;
        apu_rvalid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            apu_result_i = res[c];
            #1;
            n_cmp++; if (rvalid_o !== ids[c]) begin n_bad++; $display("[TB] FAIL il_rv[%0d]: got %b want %b", c, rvalid_o, ids[c]); end
            n_cmp++; if (result_o !== res[c]) begin n_bad++; $display("[TB] FAIL il_res[%0d]: got %h want %h", c, result_o, res[c]); end
            tick();
        end
        apu_rvalid_i = 1'b0;
        tick();
        clear_inputs();
    endtask

    // Reset with transactions outstanding, then a stale response arrives.
    task automatic test_reset_mid();
        do_reset();
        apu_gnt_i = 1'b1;
        req_i     = 4'b0100;
        tick();
        req_i     = 4'b0001;
        tick();
        req_i     = 4'b0000;
        rst_n     = 1'b0;
        tick();
        #1;
        n_cmp++; if ({gnt_o, apu_req_o, rvalid_o} !== 9'b0) begin n_bad++; $display("[TB] FAIL midrst_outputs: got gnt %b req %b rv %b want 0", gnt_o, apu_req_o, rvalid_o); end
        rst_n        = 1'b1;
        apu_rvalid_i = 1'b1;
        apu_result_i = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (rvalid_o !== 4'b0000 || result_o !== 32'h0) begin n_bad++; $display("[TB] FAIL stale_resp: got %b %h want 0000 0", rvalid_o, result_o); end
        tick();
        apu_rvalid_i = 1'b0;
        req_i        = 4'b1111;
        #1;
        n_cmp++; if (gnt_o !== 4'b0001) begin n_bad++; $display("[TB] FAIL midrst_rr: got %b want 0001", gnt_o); end
        tick();
        clear_inputs();
    endtask

`ifdef RISCV_APU_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        req_i     = 4'b1000;
        apu_gnt_i = 1'b0;
        repeat (10) tick();
        #1;
        n_cmp++; if (perf_cnt_o[3*16 +: 16] !== 16'd10) begin n_bad++; $display("[TB] FAIL perf_10: got %0d want 10", perf_cnt_o[3*16 +: 16]); end
        n_cmp++; if (perf_cnt_o[0 +: 48] !== 48'd0) begin n_bad++; $display("[TB] FAIL perf_others: got %h want 0", perf_cnt_o[0 +: 48]); end
        perf_clr_i = 1'b1;
        tick();
        perf_clr_i = 1'b0;
        #1;
        n_cmp++; if (perf_cnt_o[3*16 +: 16] !== 16'd0) begin n_bad++; $display("[TB] FAIL perf_clr: got %0d want 0", perf_cnt_o[3*16 +: 16]); end
        repeat (70000) tick();
        #1;
        n_cmp++; if (perf_cnt_o[3*16 +: 16] !== 16'hFFFF) begin n_bad++; $display("[TB] FAIL perf_sat: got %h want ffff", perf_cnt_o[3*16 +: 16]); end
        clear_inputs();
        do_reset();
    endtask
`endif

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_full();
        test_interleave();
        test_reset_mid();
`ifdef RISCV_APU_ARB_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
